spi_duty_receiver: RTL and testbench
====================================

// Module: spi_duty_receiver
// PURPOSE
//  SPI-slave front end of the slave board. Receives 8-bit frames from the master
//  and captures a 4-bit duty code. The duty code drives the switches[3:0] input of the
//  downstream PWM/LED stage. Echoes the currently held duty back on MISO during
//  every frame.
// PARAMETERS
//  SYNC_STAGES  2      flip-flop stages on each of spi_sclk / spi_mosi / spi_cs_n
//  CMD_SET      4'hA   upper nibble a frame must carry to update duty
//  STATUS_TAG   4'h5   upper nibble of the byte shifted out on MISO
//  DUTY_RESET   4'h0   duty value after reset
// PORTS
//  clock         in   1  system clock; all logic on its rising edge
//  reset         in   1  synchronous, active-high reset
//  spi_sclk      in   1  SPI clock from master, async; mode 0 (CPOL=0, CPHA=0)
//  spi_mosi      in   1  master-out data, MSB first, async
//  spi_cs_n      in   1  chip select, active-low, async
//  spi_miso      out  1  slave-out data, MSB first
//  duty          out  4  held duty code, to PWM stage switches[3:0] (bit i -> switches[i])
//  duty_update   out  1  1-cycle pulse, asserted in the same cycle duty takes a new value
//  frame_error   out  1  1-cycle pulse on a rejected frame
// BEHAVIOUR
//  - Reset values: duty=DUTY_RESET, duty_update=0, frame_error=0, spi_miso=0.
//    Reset also clears synchronisers, bit counter, shift registers and state (IDLE).
//  - All three SPI inputs pass through SYNC_STAGES FFs. Edges are detected from
//    synced current/previous values. Requirement: f_sclk <= f_clock/8.
//  - FSM IDLE -> SHIFT on synced cs_n fall:
//    - bit_cnt <= 0.
//    - tx_sr <= {STATUS_TAG, duty}.
//    - spi_miso <= STATUS_TAG[3].
//  - In SHIFT, an SCLK edge counts only when synced cs_n is 0 in that same cycle:
//    - rise: rx_sr <= {rx_sr[6:0], mosi_s}; bit_cnt increments, saturating at 9.
//    - fall: tx_sr shifts left; spi_miso <= next bit.
//    - After the 8th bit, spi_miso <= 0.
//  - SHIFT -> DONE on synced cs_n rise. DONE lasts one cycle, then goes to IDLE:
//    - bit_cnt==8 and rx_sr[7:4]==CMD_SET: duty <= rx_sr[3:0] and duty_update=1.
//    - bit_cnt==0: no pulse and no change (empty select).
//    - Any other case (short frame, over-long frame with bit_cnt==9, bad header):
//      frame_error=1 and duty unchanged.
//  - Latency: duty changes 1 cycle after the synced cs_n rise, i.e. SYNC_STAGES+2
//    clock cycles after the raw spi_cs_n rise.
//  - An SCLK edge in the same cycle as a synced cs_n rise is ignored.
//  - A cs_n fall during DONE is taken in the next IDLE cycle; no frame is lost.
//  - Writing the same duty value still pulses duty_update.
//  - Reset mid-frame aborts the frame with no pulses. If cs_n is low when reset is
//    released, the FSM stays IDLE until cs_n goes high and falls again.
//  - duty is held indefinitely between frames. spi_miso is 0 whenever not in SHIFT.
// STRUCTURE
//  - Package slave_pkg holds:
//    - typedef enum logic [1:0] {IDLE, SHIFT, DONE} spi_state_t
//    - constants FRAME_BITS=8, DUTY_W=4, default CMD_SET and STATUS_TAG
//    - typedef logic [DUTY_W-1:0] duty_t
//  - One sub-module: bit_synchronizer (parameter STAGES), instantiated three times.
//  - FSM, counters and shift registers live in this module.
// TESTING
//  1. Reset asserted with cs_n high -> duty=0, spi_miso=0, no pulses; stays so for 20 cycles.
//  2. Frame 0xA9 at f_clock/8 -> duty=4'h9, one duty_update pulse
//     SYNC_STAGES+2 cycles after the cs_n rise; MISO carried 0x50.
//  3. After duty=9, frame 0xA3 -> MISO shifted 0x59, duty=3.
//     Then frame 0x7F (bad header) -> frame_error pulse, duty stays 3.
//  4. 5-bit frame and 10-bit frame (0xA6 plus 2 extra bits) -> each gives
//     frame_error=1 and duty unchanged.
//  5. cs_n low, 3 bits clocked, reset pulsed 1 cycle, cs_n kept low then raised ->
//     duty=0, no pulses; the next full 0xAF frame sets duty=4'hF.
//  6. Two back-to-back frames 0xA1, 0xA2 with cs_n high for 4 clocks between them ->
//     two duty_update pulses, final duty=2.

Source files
------------

// File: rtl/slave_pkg.sv
// Shared types and constants for the slave-board SPI duty receiver.
package slave_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} spi_state_t;

    localparam int FRAME_BITS = 8;
    localparam int DUTY_W     = 4;

    localparam logic [3:0] CMD_SET_DEFAULT    = 4'hA;
    localparam logic [3:0] STATUS_TAG_DEFAULT = 4'h5;

    typedef logic [DUTY_W-1:0] duty_t;

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer that brings one asynchronous bit into the clock domain.
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_duty_receiver.sv
// Mode-0 SPI slave that captures a 4-bit duty code for the PWM stage and
// echoes the held duty on MISO during every frame.
module spi_duty_receiver
    import slave_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [3:0] CMD_SET     = CMD_SET_DEFAULT,
    parameter logic [3:0] STATUS_TAG  = STATUS_TAG_DEFAULT,
    parameter logic [3:0] DUTY_RESET  = 4'h0
) (
    input  logic  clock,
    input  logic  reset,
    input  logic  spi_sclk,
    input  logic  spi_mosi,
    input  logic  spi_cs_n,
    output logic  spi_miso,
    output duty_t duty,
    output logic  duty_update,
    output logic  frame_error
);

    logic sclk_s, mosi_s, cs_n_s;
    logic sclk_d, cs_n_d;

    bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clock(clock), .reset(reset), .d(spi_sclk), .q(sclk_s)
    );
    bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .clock(clock), .reset(reset), .d(spi_mosi), .q(mosi_s)
    );
    bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync_cs_n (
        .clock(clock), .reset(reset), .d(spi_cs_n), .q(cs_n_s)
    );

    logic sclk_rise, sclk_fall, cs_rise;

    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_rise   = cs_n_s & ~cs_n_d;

    spi_state_t                state;
    logic [3:0]                bit_cnt;
    logic [FRAME_BITS-1:0]     rx_sr;
    logic [FRAME_BITS-1:0]     tx_sr;
    // Set once cs_n has been seen high; a frame may only start while armed.
    // This also catches a cs_n fall that lands during DONE.
    logic                      armed;

    always_ff @(posedge clock) begin
        if (reset) begin
            sclk_d      <= 1'b0;
            cs_n_d      <= 1'b0;
            state       <= IDLE;
            bit_cnt     <= '0;
            rx_sr       <= '0;
            tx_sr       <= '0;
            armed       <= 1'b0;
            spi_miso    <= 1'b0;
            duty        <= DUTY_RESET;
            duty_update <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            sclk_d      <= sclk_s;
            cs_n_d      <= cs_n_s;
            armed       <= armed | cs_n_s;
            duty_update <= 1'b0;
            frame_error <= 1'b0;

            case (state)
                IDLE: begin
                    spi_miso <= 1'b0;
                    if (!cs_n_s && armed) begin
                        state    <= SHIFT;
                        armed    <= 1'b0;
                        bit_cnt  <= '0;
                        tx_sr    <= {STATUS_TAG, duty};
                        spi_miso <= STATUS_TAG[3];
                    end
                end

                SHIFT: begin
                    if (cs_rise) begin
                        state    <= DONE;
                        spi_miso <= 1'b0;
                    end else if (!cs_n_s) begin
                        if (sclk_rise) begin
                            rx_sr <= {rx_sr[FRAME_BITS-2:0], mosi_s};
                            if (bit_cnt != 4'd9) begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                        if (sclk_fall) begin
                            tx_sr    <= tx_sr << 1;
                            spi_miso <= (bit_cnt < 4'(FRAME_BITS)) ? tx_sr[FRAME_BITS-2] : 1'b0;
                        end
                    end
                end

                DONE: begin
                    state    <= IDLE;
                    spi_miso <= 1'b0;
                    if (bit_cnt == 4'(FRAME_BITS) && rx_sr[7:4] == CMD_SET) begin
                        duty        <= rx_sr[3:0];
                        duty_update <= 1'b1;
                    end else if (bit_cnt != 4'd0) begin
                        frame_error <= 1'b1;
                    end
                end

                default: begin
                    state    <= IDLE;
                    spi_miso <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_duty_receiver.sv
// Directed bench for spi_duty_receiver: SPI master at f_clock/8 with fixed expectations.
module tb_spi_duty_receiver;

    logic       clock = 1'b0;
    logic       reset;
    logic       spi_sclk;
    logic       spi_mosi;
    logic       spi_cs_n;
    logic       spi_miso;
    logic [3:0] duty;
    logic       duty_update;
    logic       frame_error;

    int total = 0;
    int bad   = 0;
    int upd_cnt = 0;
    int err_cnt = 0;

    spi_duty_receiver dut (
        .clock       (clock),
        .reset       (reset),
        .spi_sclk    (spi_sclk),
        .spi_mosi    (spi_mosi),
        .spi_cs_n    (spi_cs_n),
        .spi_miso    (spi_miso),
        .duty        (duty),
        .duty_update (duty_update),
        .frame_error (frame_error)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        #1;
        if (duty_update) upd_cnt++;
        if (frame_error) err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Master side of one frame: drives nbits MSB first, samples MISO at each rising SCLK.
    task automatic spi_xfer(input logic [15:0] data, input int nbits, output logic [15:0] rx);
        rx       = '0;
        spi_cs_n = 1'b0;
        for (int i = nbits - 1; i >= 0; i--) begin
            spi_mosi = data[i];
            wait_clk(4);
            rx       = {rx[14:0], spi_miso};
            spi_sclk = 1'b1;
            wait_clk(4);
            spi_sclk = 1'b0;
        end
        wait_clk(4);
        spi_mosi = 1'b0;
    endtask

    // Raise cs_n and check the result lands exactly SYNC_STAGES+2 cycles later.
    task automatic finish_frame(input string tag, input logic exp_upd, input logic exp_err,
                                input logic [3:0] exp_duty);
        spi_cs_n = 1'b1;
        wait_clk(3);
        check({tag, "_early"}, 32'({duty_update, frame_error}), 32'd0);
        wait_clk(1);
        check({tag, "_upd"},  32'(duty_update), 32'(exp_upd));
        check({tag, "_err"},  32'(frame_error), 32'(exp_err));
        check({tag, "_duty"}, 32'(duty), 32'(exp_duty));
        wait_clk(1);
        check({tag, "_pulse_end"}, 32'({duty_update, frame_error}), 32'd0);
        check({tag, "_miso_idle"}, 32'(spi_miso), 32'd0);
        wait_clk(2);
    endtask

    initial begin
        logic [15:0] rx;
        int u0, e0;

        reset    = 1'b1;
        spi_cs_n = 1'b1;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;

        // Reset with cs_n high, then 20 idle cycles
        wait_clk(5);
        check("rst_duty",  32'(duty), 32'h0);
        check("rst_miso",  32'(spi_miso), 32'd0);
        check("rst_pulse", 32'({duty_update, frame_error}), 32'd0);
        reset = 1'b0;
        wait_clk(20);
        check("idle_duty", 32'(duty), 32'h0);
        check("idle_miso", 32'(spi_miso), 32'd0);
        check("idle_upd",  32'(upd_cnt), 32'd0);
        check("idle_err",  32'(err_cnt), 32'd0);

        // 0xA9 from reset duty
        spi_xfer(16'h00A9, 8, rx);
        check("a9_miso", 32'(rx[7:0]), 32'h50);
        finish_frame("a9", 1'b1, 1'b0, 4'h9);

        // 0xA3 echoes duty 9, then a bad header
        spi_xfer(16'h00A3, 8, rx);
        check("a3_miso", 32'(rx[7:0]), 32'h59);
        finish_frame("a3", 1'b1, 1'b0, 4'h3);
        spi_xfer(16'h007F, 8, rx);
        check("7f_miso", 32'(rx[7:0]), 32'h53);
        finish_frame("7f", 1'b0, 1'b1, 4'h3);

        // Short and over-long frames
        spi_xfer(16'h0015, 5, rx);
        finish_frame("short5", 1'b0, 1'b1, 4'h3);
        spi_xfer({6'd0, 8'hA6, 2'b11}, 10, rx);
        finish_frame("long10", 1'b0, 1'b1, 4'h3);
        check("cnt_upd_mid", 32'(upd_cnt), 32'd2);
        check("cnt_err_mid", 32'(err_cnt), 32'd3);

        // Reset in the middle of a frame with cs_n held low
        spi_xfer(16'h0005, 3, rx);
        u0 = upd_cnt;
        e0 = err_cnt;
        reset = 1'b1;
        wait_clk(1);
        reset = 1'b0;
        check("midrst_duty", 32'(duty), 32'h0);
        check("midrst_miso", 32'(spi_miso), 32'd0);
        wait_clk(10);
        spi_cs_n = 1'b1;
        wait_clk(10);
        check("midrst_duty2", 32'(duty), 32'h0);
        check("midrst_upd",   32'(upd_cnt), 32'(u0));
        check("midrst_err",   32'(err_cnt), 32'(e0));
        spi_xfer(16'h00AF, 8, rx);
        check("af_miso", 32'(rx[7:0]), 32'h50);
        finish_frame("af", 1'b1, 1'b0, 4'hF);

        // Back-to-back frames, cs_n high for 4 clocks in between
        u0 = upd_cnt;
        e0 = err_cnt;
        spi_xfer(16'h00A1, 8, rx);
        check("b2b_a1_miso", 32'(rx[7:0]), 32'h5F);
        spi_cs_n = 1'b1;
        wait_clk(4);
        spi_xfer(16'h00A2, 8, rx);
        check("b2b_a2_miso", 32'(rx[7:0]), 32'h51);
        spi_cs_n = 1'b1;
        wait_clk(8);
        check("b2b_upd",  32'(upd_cnt), 32'(u0 + 2));
        check("b2b_err",  32'(err_cnt), 32'(e0));
        check("b2b_duty", 32'(duty), 32'h2);
        check("b2b_miso", 32'(spi_miso), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
